// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol/data/disparity widths and the four control-period tokens.
package tmds_pkg;

   localparam int TMDS_SYM_W  = 10;
   localparam int TMDS_DATA_W = 8;
   localparam int TMDS_CNT_W  = 5;

   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_00 = 10'h354;
   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_10 = 10'h154;
   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

   function automatic logic [TMDS_SYM_W-1:0] ctrl_token(input logic [1:0] c);
      logic [TMDS_SYM_W-1:0] tok;
      case (c)
         2'b00:   tok = CTRL_TOKEN_00;
         2'b01:   tok = CTRL_TOKEN_01;
         2'b10:   tok = CTRL_TOKEN_10;
         default: tok = CTRL_TOKEN_11;
      endcase
      return tok;
   endfunction

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side inputs and TMDS symbol outputs of one encoder channel.
interface tmds_channel_encoder_if;
   import tmds_pkg::*;

   logic [TMDS_DATA_W-1:0]        din;
   logic                          c0;
   logic                          c1;
   logic                          de;
   logic [TMDS_SYM_W-1:0]         dout;
   logic signed [TMDS_CNT_W-1:0]  disparity;

   modport master (output din, c0, c1, de, input dout, disparity);
   modport slave  (input din, c0, c1, de, output dout, disparity);

endinterface

// File: rtl/tmds_popcount8.sv
// Combinational ones count of an 8-bit word.
module tmds_popcount8 (
   input  logic [7:0] i_data,
   output logic [3:0] o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < 8; i++)
         o_count = o_count + {3'b000, i_data[i]};
   end

endmodule

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder: transition minimisation, then DC balance with running disparity.
// Define TMDS_INREG_EN to add an input capture register (latency 3 instead of 2).
module tmds_channel_encoder
   import tmds_pkg::*;
(
   input  logic                  pclk,
   input  logic                  rstin,
   tmds_channel_encoder_if.slave bus
);

   logic [TMDS_DATA_W-1:0]        w_din_s;
   logic                          w_de_s;
   logic [1:0]                    w_c_s;

`ifdef TMDS_INREG_EN
   logic [TMDS_DATA_W-1:0]        r_din_p0;
   logic                          r_de_p0;
   logic [1:0]                    r_c_p0;

   // Input capture stage
   always_ff @(posedge pclk or posedge rstin) begin
      if (rstin) begin
         r_din_p0 <= '0;
         r_de_p0  <= 1'b0;
         r_c_p0   <= 2'b00;
      end else begin
         r_din_p0 <= bus.din;
         r_de_p0  <= bus.de;
         r_c_p0   <= {bus.c1, bus.c0};
      end
   end

   assign w_din_s = r_din_p0;
   assign w_de_s  = r_de_p0;
   assign w_c_s   = r_c_p0;
`else
   assign w_din_s = bus.din;
   assign w_de_s  = bus.de;
   assign w_c_s   = {bus.c1, bus.c0};
`endif

   logic [3:0]                    w_n1d;
   logic                          w_use_xnor;
   logic [8:0]                    w_qm;
   logic [8:0]                    r_qm_p1;
   logic                          r_de_p1;
   logic [1:0]                    r_c_p1;

   tmds_popcount8 u_pop_din (
      .i_data  (w_din_s),
      .o_count (w_n1d)
   );

   assign w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_din_s[0]);

   always_comb begin
      w_qm    = '0;
      w_qm[0] = w_din_s[0];
      for (int i = 1; i < 8; i++)
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ w_din_s[i]) : (w_qm[i-1] ^ w_din_s[i]);
      w_qm[8] = ~w_use_xnor;
   end

   // Stage 1: transition-minimised word with its de/control
   always_ff @(posedge pclk or posedge rstin) begin
      if (rstin) begin
         r_qm_p1 <= '0;
         r_de_p1 <= 1'b0;
         r_c_p1  <= 2'b00;
      end else begin
         r_qm_p1 <= w_qm;
         r_de_p1 <= w_de_s;
         r_c_p1  <= w_c_s;
      end
   end

   logic [3:0]                    w_n1q;
   logic [3:0]                    w_n0q;
   logic signed [TMDS_CNT_W-1:0]  w_diff;
   logic [TMDS_SYM_W-1:0]         w_dout_d;
   logic signed [TMDS_CNT_W-1:0]  w_cnt_d;
   logic [TMDS_SYM_W-1:0]         r_dout_p2;
   logic signed [TMDS_CNT_W-1:0]  r_cnt_p2;
   logic                          w_qm8;

   tmds_popcount8 u_pop_qm (
      .i_data  (r_qm_p1[7:0]),
      .o_count (w_n1q)
   );

   assign w_n0q  = 4'd8 - w_n1q;
   assign w_qm8  = r_qm_p1[8];
   assign w_diff = $signed({1'b0, w_n1q}) - $signed({1'b0, w_n0q});

   // Counts stay in 5-bit two's complement; valid encoding keeps |cnt| <= 10.
   always_comb begin
      w_dout_d = '0;
      w_cnt_d  = r_cnt_p2;
      if (!r_de_p1) begin
         w_dout_d = ctrl_token(r_c_p1);
         w_cnt_d  = '0;
      end else if ((r_cnt_p2 == 5'sd0) || (w_n1q == w_n0q)) begin
         w_dout_d = {~w_qm8, w_qm8, w_qm8 ? r_qm_p1[7:0] : ~r_qm_p1[7:0]};
         w_cnt_d  = w_qm8 ? (r_cnt_p2 + w_diff) : (r_cnt_p2 - w_diff);
      end else if (((r_cnt_p2 > 5'sd0) && (w_n1q > w_n0q)) ||
                   ((r_cnt_p2 < 5'sd0) && (w_n0q > w_n1q))) begin
         w_dout_d = {1'b1, w_qm8, ~r_qm_p1[7:0]};
         w_cnt_d  = r_cnt_p2 - w_diff + (w_qm8 ? 5'sd2 : 5'sd0);
      end else begin
         w_dout_d = {1'b0, w_qm8, r_qm_p1[7:0]};
         w_cnt_d  = r_cnt_p2 + w_diff - (w_qm8 ? 5'sd0 : 5'sd2);
      end
   end

   // Stage 2: balanced symbol and running disparity
   always_ff @(posedge pclk or posedge rstin) begin
      if (rstin) begin
         r_dout_p2 <= '0;
         r_cnt_p2  <= '0;
      end else begin
         r_dout_p2 <= w_dout_d;
         r_cnt_p2  <= w_cnt_d;
      end
   end

   assign bus.dout      = r_dout_p2;
   assign bus.disparity = r_cnt_p2;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed tokens/balance cases, then a random video soak.
module tb_tmds_channel_encoder;

`ifdef TMDS_INREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      logic [9:0] dout;
      int         disp;
      logic [7:0] din;
      logic       de;
   } exp_t;

   logic  pclk;
   logic  rstin;
   exp_t  sb[$];
   string sb_tag[$];
   int    m_cnt;
   int    n_vec;
   int    n_err;

   tmds_channel_encoder_if bus();

   tmds_channel_encoder dut (
      .pclk  (pclk),
      .rstin (rstin),
      .bus   (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic c1, input logic c0,
                                          input logic e);
      int         n1d, n1q, n0q;
      logic       x;
      logic [8:0] qm;
      logic [9:0] r;
      if (!e) begin
         m_cnt = 0;
         case ({c1, c0})
            2'b00:   r = 10'h354;
            2'b01:   r = 10'h0AB;
            2'b10:   r = 10'h154;
            default: r = 10'h2AB;
         endcase
         return r;
      end
      n1d = $countones(d);
      x = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~x;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (m_cnt == 0 || n1q == n0q) begin
         r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         m_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
         r = {1'b1, qm[8], ~qm[7:0]};
         m_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         r = {1'b0, qm[8], qm[7:0]};
         m_cnt += n1q - n0q - (qm[8] ? 0 : 2);
      end
      return r;
   endfunction

   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] t, r;
      t = s[9] ? ~s[7:0] : s[7:0];
      r[0] = t[0];
      for (int i = 1; i < 8; i++)
         r[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
      return r;
   endfunction

   task automatic drive(input logic [7:0] d, input logic c1, input logic c0, input logic e,
                        input bit use_c, input logic [9:0] xd, input int xp, input string tag);
      exp_t       it;
      logic [9:0] md;
      bus.din = d;
      bus.c1  = c1;
      bus.c0  = c0;
      bus.de  = e;
      md = ref_enc(d, c1, c0, e);
      it.dout = use_c ? xd : md;
      it.disp = use_c ? xp : m_cnt;
      it.din  = d;
      it.de   = e;
      sb.push_back(it);
      sb_tag.push_back(tag);
   endtask

   task automatic cyc(input logic [7:0] d, input logic c1, input logic c0, input logic e,
                      input bit use_c, input logic [9:0] xd, input int xp, input string tag);
      exp_t  it;
      string t;
      int    dsp;
      @(posedge pclk);
      #1;
      if (sb.size() >= LAT) begin
         it  = sb.pop_front();
         t   = sb_tag.pop_front();
         dsp = int'(bus.disparity);
         chk({t, "_dout"}, int'(bus.dout), int'(it.dout));
         chk({t, "_disp"}, dsp, it.disp);
         if (it.de)
            chk({t, "_decode"}, int'(dec(bus.dout)), int'(it.din));
         chk({t, "_disp_bound"}, int'(dsp <= 10 && dsp >= -10), 1);
      end
      drive(d, c1, c0, e, use_c, xd, xp, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge pclk);
      rstin  = 1'b1;
      bus.de = 1'b0;
      bus.c0 = 1'b0;
      bus.c1 = 1'b0;
      bus.din = '0;
      #1;
      chk({tag, "_rst_dout"}, int'(bus.dout), 0);
      chk({tag, "_rst_disp"}, int'(bus.disparity), 0);
      sb.delete();
      sb_tag.delete();
      m_cnt = 0;
      repeat (3) @(posedge pclk);
      #1;
      chk({tag, "_rst_hold"}, int'(bus.dout), 0);
      @(negedge pclk);
      rstin = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 0, {tag, "_idle"});
   endtask

   initial begin
      logic [7:0] r8;
      logic [1:0] rc;
      n_vec = 0;
      n_err = 0;
      m_cnt = 0;
      rstin = 1'b1;
      bus.din = '0;
      bus.c0  = 1'b0;
      bus.c1  = 1'b0;
      bus.de  = 1'b0;

      do_reset("init");
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 0, "idle2");
      cyc(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0AB, 0, "tok01");
      cyc(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 10'h154, 0, "tok10");
      cyc(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 10'h2AB, 0, "tok11");
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 0, "blank");
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h100, -8, "zero1");
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h3FF, 2, "zero2");
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h100, -6, "zero3");
      cyc(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h154, 0, "midblank");
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h100, -8, "after_blank");
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 0, "blank2");
      cyc(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 10'h200, -8, "xnor_ff");
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 0, "blank3");

      for (int line = 0; line < 5; line++) begin
         for (int px = 0; px < 800; px++) begin
            if (line == 2 && px == 300)
               do_reset("midline");
            r8 = 8'($urandom);
            rc = 2'($urandom);
            cyc(r8, rc[1], rc[0], px < 640, 1'b0, 10'h000, 0, "soak");
         end
      end

      for (int i = 0; i < LAT + 1; i++)
         cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 0, "drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
